fp_issue_scheduler: RTL and testbench
=====================================

Name: fp_issue_scheduler

Overview:
Sequences the shared, non-pipelined multi-cycle FP execution unit behind the decode stage.
- Accepts FP instructions flagged by decode (f_read/f_write class instructions).
- Tracks in-flight FP destination registers in a 32-entry scoreboard.
- Stalls decode on structural, RAW or WAW hazards.
- Holds the result until the shared register-file writeback port is granted.

Parameters:
ADD_LAT, 4, execute cycles for class 0 (ADDF/SUBF); must be >= 1
MUL_LAT, 6, execute cycles for class 1 (MULTF/MULT/MULTU)
DIV_LAT, 16, execute cycles for class 2 (DIVF/DIV/DIVU)
CVT_LAT, 2, execute cycles for class 3 (CVTF2I/CVTI2F/MOVFP2I/MOVI2FP)
CNT_W, 5, latency counter width; must hold the largest *_LAT

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
issue_valid  in  1  decode presents an FP-unit instruction this cycle
issue_kill  in  1  decode instruction is squashed (should_be_killed); never accepted, never stalls
issue_class  in  2  0=add,1=mul,2=div,3=cvt/move
issue_src1  in  5  source register 1 index
issue_src1_fp  in  1  source 1 is an FP register
issue_src2  in  5  source register 2 index
issue_src2_fp  in  1  source 2 is an FP register
issue_dst  in  5  destination register index
issue_dst_fp  in  1  destination is an FP register (scoreboarded)
stall  out  1  hold decode/fetch this cycle
fpu_start  out  1  one-cycle start pulse to the FP unit
fpu_class  out  2  class of the op in flight (registered at accept)
busy  out  1  state != IDLE
wb_valid  out  1  result ready for writeback
wb_dst  out  5  destination of the pending result
wb_dst_fp  out  1  pending result targets the FP file
wb_ack  in  1  writeback port granted this cycle
scoreboard  out  32  bit i = FP register i has a pending write

Behaviour:
- Reset: all outputs and internal registers are 0; state=IDLE, counter=0, scoreboard=0.
  - Reset mid-operation discards the in-flight op; no wb_valid is produced for it.
- States:
  - IDLE: unit free.
  - EXEC: counting down.
  - WB: result held, wb_valid=1.
- unit_free = (state==IDLE) | (state==WB & wb_ack).
- hazard is computed from the registered scoreboard only:
  - (issue_src1_fp & sb[src1]) | (issue_src2_fp & sb[src2]) | (issue_dst_fp & sb[dst]).
  - No bypass: a register being written back this cycle still causes a stall this cycle.
- accept = issue_valid & ~issue_kill & unit_free & ~hazard.
- stall = issue_valid & ~issue_kill & ~accept. stall is combinational, same cycle.
- On accept at cycle T:
  - state<=EXEC; counter<=LAT(issue_class).
  - fpu_class, wb_dst and wb_dst_fp are latched.
  - fpu_start=1 at T+1 only.
  - If issue_dst_fp, sb[dst] is set.
- EXEC: counter decrements each cycle. In the cycle where counter==1, state<=WB. wb_valid=1 first at T+1+LAT.
- WB:
  - wb_valid holds, with wb_dst stable, until wb_ack.
  - On wb_ack: if wb_dst_fp, sb[wb_dst] is cleared.
  - Next state is EXEC if a new accept happens in the same cycle, else IDLE.
- Simultaneous clear and set of the same scoreboard bit: set wins. This cannot occur through normal flow, because the WAW check stalls it.
- wb_ack while not in WB is ignored.
- issue_kill=1 with issue_valid=1: no accept, stall=0, no scoreboard change.
- At most one op is in flight; issue is in order.

Test Plan:
- Reset, then issue add dst f3 at T=10 → stall=0; fpu_start=1 at T=11; wb_valid=1, wb_dst=3 at T=15; sb[3]=1 during T=11..15; wb_ack at T=15 → sb=0 and busy=0 at T=16.
- Div dst f2 in flight; issue add src1 f2 (RAW) → stall=1 every cycle until wb_ack; accept in the cycle after sb[2] clears.
- Mul in flight (sb=0, integer dst); issue cvt with no register overlap → stall=1 until the mul's wb_ack cycle, where it is accepted back-to-back; fpu_start the next cycle.
- In WB, hold wb_ack=0 for 5 cycles → wb_valid and wb_dst remain stable, and a new issue stalls; wb_ack=1 → release.
- issue_valid=1, issue_kill=1 while busy → stall=0, scoreboard unchanged, no fpu_start.
- Assert reset during EXEC of a div to f7 → next cycle busy=0, sb=0, wb_valid=0, and no wb_valid follows.

Source files
------------

// File: rtl/fp_issue_scheduler_if.sv
// Issue and writeback handshake between decode, the FP issue scheduler and the
// register-file writeback arbiter.
interface fp_issue_scheduler_if;
  logic       issue_valid;
  logic       issue_kill;
  logic [1:0] issue_class;
  logic [4:0] issue_src1;
  logic       issue_src1_fp;
  logic [4:0] issue_src2;
  logic       issue_src2_fp;
  logic [4:0] issue_dst;
  logic       issue_dst_fp;
  logic       stall;
  logic       wb_valid;
  logic [4:0] wb_dst;
  logic       wb_dst_fp;
  logic       wb_ack;

  modport master (
    output issue_valid, issue_kill, issue_class, issue_src1, issue_src1_fp,
           issue_src2, issue_src2_fp, issue_dst, issue_dst_fp, wb_ack,
    input  stall, wb_valid, wb_dst, wb_dst_fp
  );

  modport slave (
    input  issue_valid, issue_kill, issue_class, issue_src1, issue_src1_fp,
           issue_src2, issue_src2_fp, issue_dst, issue_dst_fp, wb_ack,
    output stall, wb_valid, wb_dst, wb_dst_fp
  );
endinterface

// File: rtl/fp_issue_scheduler.sv
// Issue control for the shared, non-pipelined multi-cycle FP unit: hazard
// stalls against a 32-entry destination scoreboard and a held writeback result.
module fp_issue_scheduler #(
  parameter int ADD_LAT = 4,
  parameter int MUL_LAT = 6,
  parameter int DIV_LAT = 16,
  parameter int CVT_LAT = 2,
  parameter int CNT_W   = 5
) (
  input  logic                clk,
  input  logic                reset,
  fp_issue_scheduler_if.slave bus,
  output logic                fpu_start,
  output logic [1:0]          fpu_class,
  output logic                busy,
  output logic [31:0]         scoreboard
);

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  state_t           state;
  logic [CNT_W-1:0] counter;
  logic [CNT_W-1:0] issue_lat;
  logic             unit_free;
  logic             hazard;
  logic             accept;
  logic             wb_release;
  logic [31:0]      sb_next;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    issue_lat = CNT_W'(ADD_LAT);
    case (bus.issue_class)
      2'd1:    issue_lat = CNT_W'(MUL_LAT);
      2'd2:    issue_lat = CNT_W'(DIV_LAT);
      2'd3:    issue_lat = CNT_W'(CVT_LAT);
      default: issue_lat = CNT_W'(ADD_LAT);
    endcase
  end

  assign wb_release = (state == WB) && bus.wb_ack;
  assign unit_free  = (state == IDLE) || wb_release;

  // Registered scoreboard only: a result retiring this cycle still stalls.
  assign hazard = (bus.issue_src1_fp & scoreboard[bus.issue_src1])
                | (bus.issue_src2_fp & scoreboard[bus.issue_src2])
                | (bus.issue_dst_fp  & scoreboard[bus.issue_dst]);

  assign accept    = bus.issue_valid & ~bus.issue_kill & unit_free & ~hazard;
  assign bus.stall = bus.issue_valid & ~bus.issue_kill & ~accept;

  always_comb begin
    sb_next = scoreboard;
    if (wb_release && bus.wb_dst_fp) sb_next[bus.wb_dst] = 1'b0;
    // Set after clear so a same-bit collision leaves the bit set.
    if (accept && bus.issue_dst_fp) sb_next[bus.issue_dst] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      counter       <= '0;
      fpu_start     <= 1'b0;
      fpu_class     <= 2'd0;
      busy          <= 1'b0;
      scoreboard    <= '0;
      bus.wb_valid  <= 1'b0;
      bus.wb_dst    <= 5'd0;
      bus.wb_dst_fp <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      fpu_start  <= accept;
      scoreboard <= sb_next;

      if (accept) begin
        fpu_class     <= bus.issue_class;
        bus.wb_dst    <= bus.issue_dst;
        bus.wb_dst_fp <= bus.issue_dst_fp;
        counter       <= issue_lat;
      end

      case (state)
        IDLE: begin
          if (accept) begin
            state <= EXEC;
            busy  <= 1'b1;
          end
        end
        EXEC: begin
          counter <= counter - 1'b1;
          if (counter == CNT_W'(1)) begin
            state        <= WB;
            bus.wb_valid <= 1'b1;
          end
        end
        WB: begin
          if (bus.wb_ack) begin
            bus.wb_valid <= 1'b0;
            if (accept) begin
              state <= EXEC;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_issue_scheduler.sv
// Directed bench for fp_issue_scheduler: inputs change 1 ns after the rising
// edge, outputs are sampled on the falling edge.
module tb_fp_issue_scheduler;

  logic        clk;
  logic        reset;
  logic        fpu_start;
  logic [1:0]  fpu_class;
  logic        busy;
  logic [31:0] scoreboard;

  int checks = 0;
  int errors = 0;

  fp_issue_scheduler_if bus ();

  fp_issue_scheduler dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus.slave),
    .fpu_start  (fpu_start),
    .fpu_class  (fpu_class),
    .busy       (busy),
    .scoreboard (scoreboard)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic k, input logic [1:0] cls,
                       input logic [4:0] s1, input logic s1fp,
                       input logic [4:0] s2, input logic s2fp,
                       input logic [4:0] d, input logic dfp);
    bus.issue_valid   = v;
    bus.issue_kill    = k;
    bus.issue_class   = cls;
    bus.issue_src1    = s1;
    bus.issue_src1_fp = s1fp;
    bus.issue_src2    = s2;
    bus.issue_src2_fp = s2fp;
    bus.issue_dst     = d;
    bus.issue_dst_fp  = dfp;
  endtask

  task automatic no_issue();
    drive(1'b0, 1'b0, 2'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
  endtask

  initial begin
    int wb_seen;

    reset      = 1'b1;
    bus.wb_ack = 1'b0;
    no_issue();
    next();
    next();
    reset = 1'b0;

    // Reset state
    sample();
    check("rst_busy", busy, 0);
    check("rst_stall", bus.stall, 0);
    check("rst_wb_valid", bus.wb_valid, 0);
    check("rst_sb", scoreboard, 0);
    check("rst_fpu_start", fpu_start, 0);
    next();

    // Add to f3: accepted at T, start at T+1, result at T+5, retire at T+6
    drive(1'b1, 1'b0, 2'd0, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1);
    sample();
    check("add_accept_stall", bus.stall, 0);
    next();
    no_issue();
    sample();
    check("add_fpu_start", fpu_start, 1);
    check("add_fpu_class", fpu_class, 0);
    check("add_busy", busy, 1);
    check("add_sb_set", scoreboard, 32'h0000_0008);
    next();
    sample();
    check("add_start_pulse", fpu_start, 0);
    next();
    next();
    sample();
    check("add_no_early_wb", bus.wb_valid, 0);
    next();
    bus.wb_ack = 1'b1;
    sample();
    check("add_wb_valid", bus.wb_valid, 1);
    check("add_wb_dst", bus.wb_dst, 3);
    check("add_wb_dst_fp", bus.wb_dst_fp, 1);
    check("add_sb_in_wb", scoreboard, 32'h0000_0008);
    next();
    bus.wb_ack = 1'b0;
    sample();
    check("add_sb_clear", scoreboard, 0);
    check("add_idle", busy, 0);
    check("add_wb_drop", bus.wb_valid, 0);
    next();

    // Div to f2, then RAW add reading f2
    drive(1'b1, 1'b0, 2'd2, 5'd0, 1'b0, 5'd0, 1'b0, 5'd2, 1'b1);
    sample();
    check("div_accept_stall", bus.stall, 0);
    next();
    drive(1'b1, 1'b0, 2'd0, 5'd2, 1'b1, 5'd6, 1'b1, 5'd4, 1'b1);
    for (int i = 0; i < 16; i++) begin
      sample();
      check("raw_stall_exec", bus.stall, 1);
      check("raw_no_wb_yet", bus.wb_valid, 0);
      next();
    end
    bus.wb_ack = 1'b1;
    sample();
    check("div_wb_valid", bus.wb_valid, 1);
    check("div_wb_dst", bus.wb_dst, 2);
    check("raw_stall_no_bypass", bus.stall, 1);
    next();
    bus.wb_ack = 1'b0;
    sample();
    check("raw_accept", bus.stall, 0);
    check("raw_sb_cleared", scoreboard, 0);
    next();
    no_issue();
    sample();
    check("raw_add_start", fpu_start, 1);
    check("raw_add_sb", scoreboard, 32'h0000_0010);
    next();
    next();
    next();
    next();
    bus.wb_ack = 1'b1;
    sample();
    check("raw_add_wb", bus.wb_valid, 1);
    check("raw_add_wb_dst", bus.wb_dst, 4);
    next();
    bus.wb_ack = 1'b0;

    // Mul to integer r5; structural stall on a non-overlapping cvt
    drive(1'b1, 1'b0, 2'd1, 5'd1, 1'b0, 5'd2, 1'b0, 5'd5, 1'b0);
    sample();
    check("mul_accept_stall", bus.stall, 0);
    next();
    drive(1'b1, 1'b0, 2'd3, 5'd8, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1);
    sample();
    check("mul_sb_int_dst", scoreboard, 0);
    check("mul_fpu_class", fpu_class, 1);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) sample();
      check("struct_stall", bus.stall, 1);
      next();
    end
    bus.wb_ack = 1'b1;
    sample();
    check("mul_wb_valid", bus.wb_valid, 1);
    check("mul_wb_dst", bus.wb_dst, 5);
    check("mul_wb_dst_fp", bus.wb_dst_fp, 0);
    check("cvt_b2b_accept", bus.stall, 0);
    next();
    bus.wb_ack = 1'b0;
    no_issue();
    sample();
    check("cvt_fpu_start", fpu_start, 1);
    check("cvt_fpu_class", fpu_class, 3);
    check("cvt_sb", scoreboard, 32'h0000_0200);
    check("cvt_wb_dropped", bus.wb_valid, 0);
    next();
    sample();
    check("cvt_exec", bus.wb_valid, 0);
    next();

    // Cvt result held 5 cycles without ack while a new add stalls
    drive(1'b1, 1'b0, 2'd0, 5'd1, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1);
    for (int i = 0; i < 5; i++) begin
      sample();
      check("hold_wb_valid", bus.wb_valid, 1);
      check("hold_wb_dst", bus.wb_dst, 9);
      check("hold_stall", bus.stall, 1);
      next();
    end
    bus.wb_ack = 1'b1;
    sample();
    check("hold_release_accept", bus.stall, 0);
    next();
    bus.wb_ack = 1'b0;
    no_issue();
    sample();
    check("hold_sb_swap", scoreboard, 32'h0000_0400);
    check("hold_new_start", fpu_start, 1);
    next();

    // Killed issue while busy, including one that would hit a WAW hazard
    drive(1'b1, 1'b1, 2'd1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1);
    sample();
    check("kill_no_stall", bus.stall, 0);
    next();
    no_issue();
    sample();
    check("kill_no_start", fpu_start, 0);
    check("kill_sb_same", scoreboard, 32'h0000_0400);
    next();
    next();
    bus.wb_ack = 1'b1;
    sample();
    check("add10_wb_valid", bus.wb_valid, 1);
    check("add10_wb_dst", bus.wb_dst, 10);
    next();
    bus.wb_ack = 1'b0;
    sample();
    check("add10_idle", busy, 0);
    check("add10_sb_clear", scoreboard, 0);
    next();

    // Reset in the middle of a div to f7
    drive(1'b1, 1'b0, 2'd2, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1);
    next();
    no_issue();
    next();
    next();
    sample();
    check("div7_busy", busy, 1);
    check("div7_sb", scoreboard, 32'h0000_0080);
    next();
    reset = 1'b1;
    next();
    reset = 1'b0;
    sample();
    check("midrst_busy", busy, 0);
    check("midrst_sb", scoreboard, 0);
    check("midrst_wb_valid", bus.wb_valid, 0);
    check("midrst_fpu_start", fpu_start, 0);
    wb_seen = 0;
    for (int i = 0; i < 25; i++) begin
      next();
      sample();
      if (bus.wb_valid === 1'b1 || busy === 1'b1) wb_seen++;
    end
    check("midrst_no_late_wb", wb_seen, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
